nios2_qsys_nios2_cpu_mult_seq: RTL and testbench
================================================

# nios2_qsys_nios2_cpu_mult_seq

Parametrised sequential multiplier that replaces the fixed three-instance 16x16 partial-product cell in the Nios II execute/memory path. It forms the full 2*WIDTH-bit product by accumulating one SLICE-wide partial product per cycle through a single WIDTH x SLICE multiplier. It supports signed, unsigned and mixed-sign operands, and returns either the low or the high result word. It uses a start/busy/done handshake and a pipeline stall enable, so it can also serve cores with no dedicated multiplier blocks to spare.

## Interface
Parameters:
- WIDTH, 32, operand and result width; must be a multiple of SLICE.
- SLICE, 16, bits of src2 consumed per accumulate cycle; N = WIDTH/SLICE accumulate cycles.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  pipeline enable; when low, all state freezes.
- start  in  1  request; accepted only in IDLE with en=1.
- mode  in  2  operation select: 00 MUL (low word); 01 MULXSS (high word, signed x signed); 10 MULXSU (high word, src1 signed x src2 unsigned); 11 MULXUU (high word, unsigned x unsigned).
- src1  in  WIDTH  multiplicand; sampled with start.
- src2  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high from the cycle after acceptance through the FINISH cycle.
- done  out  1  one-cycle pulse, stretched while en=0; result is valid when done is high.
- result  out  WIDTH  selected product word; held until the next done.

## Operation
- States: IDLE, ACCUM, FINISH.
- IDLE, start & en: register the operands as magnitudes.
  - src1 is signed for modes 01 and 10; src2 is signed for mode 01.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) fits in the WIDTH-bit unsigned magnitude.
  - neg = sign1 XOR sign2 (unsigned operands count as sign 0).
  - Clear the 2*WIDTH-bit accumulator, set cnt=0, go to ACCUM.
- ACCUM: acc += mag1 * mag2[cnt*SLICE +: SLICE] << (cnt*SLICE), then cnt++. After the update with cnt=N-1, go to FINISH.
- FINISH: p = neg ? -acc : acc, computed modulo 2^(2*WIDTH).
  - Mode 00: result = p[WIDTH-1:0]. Otherwise: result = p[2*WIDTH-1:WIDTH].
  - Set done=1 and go to IDLE.
- done clears on the next enabled edge.
- start while busy is ignored; no queueing.
- start in the done cycle (state is IDLE) is accepted, giving back-to-back operation.
- en=0 freezes state, cnt, acc, operands, busy, done and result. start is ignored while en=0.
- reset (any state, including mid-operation, regardless of en) forces IDLE.
  - busy=0, done=0, result=0, acc=0, cnt=0.
  - An aborted operation produces no done.
- Reset values: busy=0, done=0, result=0.

## Timing
- With en=1 throughout, numbering cycles from the one where start is high as cycle 0:
  - Cycle 0: start is sampled at the end-of-cycle edge.
  - Cycles 1..N: ACCUM.
  - Cycle N+1: FINISH.
  - Cycle N+2: done=1 and result valid.
- Latency is N+2 cycles; defaults (WIDTH=32, SLICE=16) give 4.
- busy is high in cycles 1..N+1.
- Throughput: one operation per N+2 cycles.
- Each cycle with en=0 adds exactly one cycle to the latency.
- Only one multiplier of WIDTH x SLICE bits is used. The accumulator add is 2*WIDTH bits wide, with no registered pipelining inside the cycle.

## Test plan
- 1. mode=00, src1=0x00000003, src2=0x00000005, defaults. Required: busy in cycles 1-3, done in cycle 4, result=0x0000000F.
- 2. src1=0xFFFFFFFF, src2=0x00000002. mode=01: result=0xFFFFFFFF (product -2). mode=11: result=0x00000001. mode=00: result=0xFFFFFFFE.
- 3. src1=0x80000000, src2=0x80000000. mode=01: result=0x40000000. mode=10: result=0xC0000000. mode=11: result=0x40000000.
- 4. Case 1 with en=0 for cycles 2-4. Required: done in cycle 7, held while en=0, result=0x0000000F. A start pulse during the stall is ignored.
- 5. start held high continuously, src1=7, src2=6, mode=00. Required: done in cycles 4, 8, 12, each with result=42. Starts during busy are ignored.
- 6. Assert reset in cycle 2 of a mode=01 operation. Required: next cycle busy=0, done=0, result=0, and no done follows. A subsequent 0x0000FFFF x 0x0000FFFF, mode=00, gives result=0xFFFE0001.
- Repeat cases 1-3 with WIDTH=32 and SLICE=8 (latency 6) and with WIDTH=64 and SLICE=32. Results must match a reference model.

Source files
------------

// File: rtl/nios2_qsys_nios2_cpu_mult_seq.sv
// ---------------------------------------------------------------------------
// nios2_qsys_nios2_cpu_mult_seq
//
// Sequential WIDTH x WIDTH multiplier. It forms the 2*WIDTH-bit product one
// SLICE-wide partial product per cycle, using a single WIDTH x SLICE
// multiplier and a 2*WIDTH-bit accumulator. Operands are held as magnitudes
// with a separate sign flag. The sign is applied once, in the FINISH cycle.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-high reset (wins over en)
//   en      pipeline enable; low freezes all state
//   start   operation request, accepted in IDLE with en=1
//   mode    00 MUL (low word), 01 MULXSS, 10 MULXSU, 11 MULXUU (high word)
//   src1    multiplicand, sampled with start
//   src2    multiplier, sampled with start
//   busy    high from the cycle after acceptance through the FINISH cycle
//   done    one-cycle result-valid pulse (stretched while en=0)
//   result  selected product word, held until the next done
// ---------------------------------------------------------------------------
module nios2_qsys_nios2_cpu_mult_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINISH
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [PW-1:0]      acc;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic               neg;
    logic               sel_hi;

    logic               sign1;
    logic               sign2;
    logic               last_slice;
    int                 shamt;
    logic [WIDTH-1:0]   mag2_sh;
    logic [SLICE-1:0]   slice_bits;
    logic [WIDTH+SLICE-1:0] pp;
    logic [PW-1:0]      pp_ext;
    logic [PW-1:0]      pp_sh;
    logic [PW-1:0]      prod;

    // Two's-complement magnitude. The most negative value maps onto itself,
    // which is exactly its magnitude when read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             s);
        return s ? (~v + WIDTH'(1)) : v;
    endfunction

    // Re-apply the product sign, modulo 2^(2*WIDTH).
    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] a,
                                                 input logic          n);
        return n ? (~a + PW'(1)) : a;
    endfunction

    // src1 is signed for MULXSS/MULXSU; src2 only for MULXSS.
    assign sign1 = src1[WIDTH-1] & ((mode == 2'b01) | (mode == 2'b10));
    assign sign2 = src2[WIDTH-1] & (mode == 2'b01);

    assign last_slice = (cnt == CNT_W'(N - 1));
    assign busy       = (state != IDLE);

    // One partial product per cycle. Both factors are zero-extended to a
    // common width, so synthesis keeps only the WIDTH x SLICE core.
    always_comb begin
        shamt      = int'(cnt) * SLICE;
        mag2_sh    = mag2 >> shamt;
        slice_bits = mag2_sh[SLICE-1:0];
        pp         = {{SLICE{1'b0}}, mag1} * {{WIDTH{1'b0}}, slice_bits};
        pp_ext     = '0;
        pp_ext[WIDTH+SLICE-1:0] = pp;
        pp_sh      = pp_ext << shamt;
        prod       = apply_sign(acc, neg);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (last_slice) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else if (en) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag1   <= magnitude(src1, sign1);
                        mag2   <= magnitude(src2, sign2);
                        neg    <= sign1 ^ sign2;
                        sel_hi <= (mode != 2'b00);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + pp_sh;
                    cnt <= cnt + CNT_W'(1);
                end
                FINISH: begin
                    done   <= 1'b1;
                    result <= sel_hi ? prod[PW-1:WIDTH] : prod[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_qsys_nios2_cpu_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_nios2_qsys_nios2_cpu_mult_seq
//
// Directed bench for the sequential multiplier. Three instances are used:
// 32/16 (full set of cases), 32/8 and 64/32 (arithmetic cases repeated).
// ---------------------------------------------------------------------------
module tb_nios2_qsys_nios2_cpu_mult_seq;

    logic        clk;
    logic        reset;
    logic        en;
    logic [1:0]  mode;
    logic        start0, start1, start2;
    logic [31:0] a32, b32;
    logic [63:0] a64, b64;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [31:0] res0, res1;
    logic [63:0] res2;

    int          tests;
    int          fails;
    int          sel;
    logic        sel_done;
    logic [63:0] sel_res;
    logic        seen;

    nios2_qsys_nios2_cpu_mult_seq #(.WIDTH(32), .SLICE(16)) dut0 (
        .clk(clk), .reset(reset), .en(en), .start(start0), .mode(mode),
        .src1(a32), .src2(b32), .busy(busy0), .done(done0), .result(res0));

    nios2_qsys_nios2_cpu_mult_seq #(.WIDTH(32), .SLICE(8)) dut1 (
        .clk(clk), .reset(reset), .en(en), .start(start1), .mode(mode),
        .src1(a32), .src2(b32), .busy(busy1), .done(done1), .result(res1));

    nios2_qsys_nios2_cpu_mult_seq #(.WIDTH(64), .SLICE(32)) dut2 (
        .clk(clk), .reset(reset), .en(en), .start(start2), .mode(mode),
        .src1(a64), .src2(b64), .busy(busy2), .done(done2), .result(res2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        sel_done = done2;
        sel_res  = res2;
        case (sel)
            0: begin sel_done = done0; sel_res = {32'b0, res0}; end
            1: begin sel_done = done1; sel_res = {32'b0, res1}; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Start one operation on the chosen instance, wait (bounded) for done,
    // then check latency and result.
    task automatic run_op(input string tag, input int which, input logic [1:0] m,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        sel  = which;
        mode = m;
        a32  = a[31:0];
        b32  = b[31:0];
        a64  = a;
        b64  = b;
        case (which)
            0:       start0 = 1'b1;
            1:       start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        lat = 1;
        while (!sel_done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check(tag, sel_res, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests  = 0;
        fails  = 0;
        sel    = 0;
        reset  = 1'b1;
        en     = 1'b1;
        mode   = 2'b00;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        a32    = '0;
        b32    = '0;
        a64    = '0;
        b64    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_bit("rst_busy", busy0, 1'b0);
        check_bit("rst_done", done0, 1'b0);
        check("rst_result", {32'b0, res0}, 64'h0);

        // Case 1: cycle-accurate 3 x 5
        @(posedge clk); #1;
        sel = 0; mode = 2'b00; a32 = 32'd3; b32 = 32'd5; start0 = 1'b1;
        check_bit("c1_busy_c0", busy0, 1'b0);
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check_bit($sformatf("c1_busy_c%0d", c), busy0, 1'b1);
            check_bit($sformatf("c1_done_c%0d", c), done0, 1'b0);
            @(posedge clk); #1;
        end
        check_bit("c1_done_c4", done0, 1'b1);
        check_bit("c1_busy_c4", busy0, 1'b0);
        check("c1_result", {32'b0, res0}, 64'h0000000F);
        @(posedge clk); #1;
        check_bit("c1_done_c5", done0, 1'b0);
        check("c1_result_hold", {32'b0, res0}, 64'h0000000F);

        // Case 2 and 3 on 32/16
        run_op("c2_xss", 0, 2'b01, 64'hFFFFFFFF, 64'h2, 64'hFFFFFFFF, 4);
        run_op("c2_xuu", 0, 2'b11, 64'hFFFFFFFF, 64'h2, 64'h00000001, 4);
        run_op("c2_mul", 0, 2'b00, 64'hFFFFFFFF, 64'h2, 64'hFFFFFFFE, 4);
        run_op("c3_xss", 0, 2'b01, 64'h80000000, 64'h80000000, 64'h40000000, 4);
        run_op("c3_xsu", 0, 2'b10, 64'h80000000, 64'h80000000, 64'hC0000000, 4);
        run_op("c3_xuu", 0, 2'b11, 64'h80000000, 64'h80000000, 64'h40000000, 4);

        // Case 4: en low in cycles 2-4, start pulses ignored while stalled
        @(posedge clk); #1;
        sel = 0; mode = 2'b00; a32 = 32'd3; b32 = 32'd5; start0 = 1'b1;   // cycle 0
        @(posedge clk); #1; start0 = 1'b0;                                 // cycle 1
        @(posedge clk); #1; en = 1'b0;                                     // cycle 2
        @(posedge clk); #1; start0 = 1'b1;                                 // cycle 3
        @(posedge clk); #1; start0 = 1'b0;                                 // cycle 4
        @(posedge clk); #1; en = 1'b1;                                     // cycle 5
        check_bit("c4_busy_c5", busy0, 1'b1);
        check_bit("c4_done_c5", done0, 1'b0);
        @(posedge clk); #1;                                                // cycle 6
        check_bit("c4_busy_c6", busy0, 1'b1);
        check_bit("c4_done_c6", done0, 1'b0);
        @(posedge clk); #1;                                                // cycle 7
        check_bit("c4_done_c7", done0, 1'b1);
        check_bit("c4_busy_c7", busy0, 1'b0);
        check("c4_result", {32'b0, res0}, 64'h0000000F);
        en = 1'b0; start0 = 1'b1; a32 = 32'd2;
        @(posedge clk); #1;                                                // cycle 8
        check_bit("c4_done_held", done0, 1'b1);
        check_bit("c4_busy_stall", busy0, 1'b0);
        check("c4_result_held", {32'b0, res0}, 64'h0000000F);
        en = 1'b1; start0 = 1'b0;
        @(posedge clk); #1;                                                // cycle 9
        check_bit("c4_done_c9", done0, 1'b0);
        check_bit("c4_start_ignored", busy0, 1'b0);

        // Case 5: start held high, back-to-back operations
        @(posedge clk); #1;
        sel = 0; mode = 2'b00; a32 = 32'd7; b32 = 32'd6; start0 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            check_bit($sformatf("c5_done_c%0d", c), done0, (c % 4) == 0);
            if ((c % 4) == 0)
                check($sformatf("c5_result_c%0d", c), {32'b0, res0}, 64'd42);
            if (c == 12)
                start0 = 1'b0;
        end

        // Case 6: reset mid-operation
        @(posedge clk); #1;
        mode = 2'b01; a32 = 32'hFFFFFFFF; b32 = 32'd2; start0 = 1'b1;      // cycle 0
        @(posedge clk); #1; start0 = 1'b0;                                 // cycle 1
        @(posedge clk); #1; reset = 1'b1;                                  // cycle 2
        @(posedge clk); #1; reset = 1'b0;                                  // cycle 3
        check_bit("c6_busy", busy0, 1'b0);
        check_bit("c6_done", done0, 1'b0);
        check("c6_result", {32'b0, res0}, 64'h0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done0) seen = 1'b1;
        end
        check_bit("c6_no_done", seen, 1'b0);
        run_op("c6_ffff", 0, 2'b00, 64'h0000FFFF, 64'h0000FFFF, 64'hFFFE0001, 4);

        // WIDTH=32, SLICE=8
        run_op("s8_c1",     1, 2'b00, 64'h3, 64'h5, 64'h0000000F, 6);
        run_op("s8_c2_xss", 1, 2'b01, 64'hFFFFFFFF, 64'h2, 64'hFFFFFFFF, 6);
        run_op("s8_c2_xuu", 1, 2'b11, 64'hFFFFFFFF, 64'h2, 64'h00000001, 6);
        run_op("s8_c2_mul", 1, 2'b00, 64'hFFFFFFFF, 64'h2, 64'hFFFFFFFE, 6);
        run_op("s8_c3_xss", 1, 2'b01, 64'h80000000, 64'h80000000, 64'h40000000, 6);
        run_op("s8_c3_xsu", 1, 2'b10, 64'h80000000, 64'h80000000, 64'hC0000000, 6);
        run_op("s8_c3_xuu", 1, 2'b11, 64'h80000000, 64'h80000000, 64'h40000000, 6);

        // WIDTH=64, SLICE=32
        run_op("w64_c1",     2, 2'b00, 64'h3, 64'h5, 64'hF, 4);
        run_op("w64_c2_xss", 2, 2'b01, 64'hFFFFFFFF_FFFFFFFF, 64'h2, 64'hFFFFFFFF_FFFFFFFF, 4);
        run_op("w64_c2_xuu", 2, 2'b11, 64'hFFFFFFFF_FFFFFFFF, 64'h2, 64'h1, 4);
        run_op("w64_c2_mul", 2, 2'b00, 64'hFFFFFFFF_FFFFFFFF, 64'h2, 64'hFFFFFFFF_FFFFFFFE, 4);
        run_op("w64_c3_xss", 2, 2'b01, 64'h80000000_00000000, 64'h80000000_00000000,
               64'h40000000_00000000, 4);
        run_op("w64_c3_xsu", 2, 2'b10, 64'h80000000_00000000, 64'h80000000_00000000,
               64'hC0000000_00000000, 4);
        run_op("w64_c3_xuu", 2, 2'b11, 64'h80000000_00000000, 64'h80000000_00000000,
               64'h40000000_00000000, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
